seq_controller: RTL and testbench

- Next-generation VeriRISC sequencer: owns the 8-phase instruction counter internally instead of taking a phase input.
- Decodes a parametrised-width opcode and drives the CPU datapath/memory control strobes.
- Adds a memory-ready stall handshake, a halted state with resume, and a global run enable.
- Sits between the instruction register/accumulator and memory/PC.

---
 rtl/veririsc_pkg.sv | 68 ++++++
 rtl/seq_controller_if.sv | 47 ++++
 rtl/seq_controller_phase_counter.sv | 26 ++
 rtl/seq_controller.sv | 160 ++++++++++++++++
 tb/tb_seq_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC sequencer definitions: opcodes, phase names, control-word
// bit positions, sequencer state and the opcode decode helper.
package veririsc_pkg;

  localparam int PH_WIDTH = 3;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_HLT = 3'd0;
  localparam opcode_t OP_SKZ = 3'd1;
  localparam opcode_t OP_ADD = 3'd2;
  localparam opcode_t OP_AND = 3'd3;
  localparam opcode_t OP_XOR = 3'd4;
  localparam opcode_t OP_LDA = 3'd5;
  localparam opcode_t OP_STO = 3'd6;
  localparam opcode_t OP_JMP = 3'd7;

  localparam logic [PH_WIDTH-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PH_WIDTH-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PH_WIDTH-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PH_WIDTH-1:0] PH_IDLE       = 3'd3;
  localparam logic [PH_WIDTH-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PH_WIDTH-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PH_WIDTH-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PH_WIDTH-1:0] PH_STORE      = 3'd7;

  // Control word ordered {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}.
  localparam int CW_WIDTH  = 9;
  localparam int CW_SEL    = 8;
  localparam int CW_RD     = 7;
  localparam int CW_LD_IR  = 6;
  localparam int CW_HALT   = 5;
  localparam int CW_INC_PC = 4;
  localparam int CW_LD_AC  = 3;
  localparam int CW_LD_PC  = 2;
  localparam int CW_WR     = 1;
  localparam int CW_DATA_E = 0;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic hlt;
    logic skz;
    logic aluop;
    logic sto;
    logic jmp;
  } decode_t;

  // An opcode outside 0..7 decodes to all-zero flags, i.e. a NOP.
  function automatic decode_t decode_op(input opcode_t code, input logic legal);
    decode_t d;
    d = '0;
    if (legal) begin
      d.hlt   = (code == OP_HLT);
      d.skz   = (code == OP_SKZ);
      d.aluop = (code inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});
      d.sto   = (code == OP_STO);
      d.jmp   = (code == OP_JMP);
    end
    return d;
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Sequencer-to-datapath bundle. The trap line exists only when
// SEQ_ILLEGAL_TRAP_EN is defined.
interface seq_controller_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH  = 3
);

  logic                    enable;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    resume;

  logic [PHASE_WIDTH-1:0]  phase;
  logic                    halted;
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    inc_pc;
  logic                    halt;
  logic                    ld_pc;
  logic                    data_e;
  logic                    ld_ac;
  logic                    wr;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic                    trap;
`endif

  modport master (
`ifdef SEQ_ILLEGAL_TRAP_EN
    output trap,
`endif
    input  enable, opcode, zero, mem_ready, resume,
    output phase, halted,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
  );

  modport slave (
`ifdef SEQ_ILLEGAL_TRAP_EN
    input  trap,
`endif
    output enable, opcode, zero, mem_ready, resume,
    input  phase, halted,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
  );

endinterface

// File: rtl/seq_controller_phase_counter.sv
// Instruction phase counter: synchronous load has priority over increment;
// wraps naturally from the all-ones value back to zero.
module phase_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers are written with <= so every flop samples pre-edge values;
  // a blocking = here would let downstream logic in the same edge see the new count.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_controller.sv
// VeriRISC sequencer: internal 8-phase counter, opcode decode, strobe table,
// memory-ready stall and HALTED/resume. Optional SEQ_ILLEGAL_TRAP_EN traps opcodes > 7.
module seq_controller
  import veririsc_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst_,
  seq_controller_if.master bus
);

  seq_state_t              state_q;
  seq_state_t              state_d;
  logic [PHASE_WIDTH-1:0]  phase;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    legal;
  decode_t                 dec;
  logic                    stall;
  logic                    trap_req;
  logic                    halt_req;
  logic                    cnt_en;
  logic                    cnt_load;
  ctrl_word_t              run_cw;
  ctrl_word_t              cw;

  assign opcode = bus.opcode;
  assign legal  = ((opcode >> 3) == '0);
  assign dec    = decode_op(opcode[2:0], legal);

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign trap_req = ~legal;
`else
  assign trap_req = 1'b0;
`endif

  // Only the memory-access phases wait on mem_ready; the inc_pc phases never do.
  assign stall = ~bus.mem_ready &
                 ((phase == PH_INST_FETCH) |
                  ((phase == PH_OP_FETCH) & dec.aluop) |
                  ((phase == PH_STORE)    & dec.sto));

  assign halt_req = bus.enable & (phase == PH_OP_ADDR) & (dec.hlt | trap_req);

  phase_counter #(
    .WIDTH(PHASE_WIDTH)
  ) u_phase_counter (
    .clk     (clk),
    .rst_    (rst_),
    .en      (cnt_en),
    .load    (cnt_load),
    .load_val(PHASE_WIDTH'(PH_OP_FETCH)),
    .count   (phase)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    run_cw = '0;
    case (phase)
      PH_INST_ADDR: begin
        run_cw[CW_SEL] = 1'b1;
      end
      PH_INST_FETCH: begin
        run_cw[CW_SEL] = 1'b1;
        run_cw[CW_RD]  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        run_cw[CW_SEL]   = 1'b1;
        run_cw[CW_RD]    = 1'b1;
        run_cw[CW_LD_IR] = 1'b1;
      end
      PH_OP_ADDR: begin
        run_cw[CW_HALT]   = dec.hlt;
        run_cw[CW_INC_PC] = 1'b1;
      end
      PH_OP_FETCH: begin
        run_cw[CW_RD] = dec.aluop;
      end
      PH_ALU_OP: begin
        run_cw[CW_RD]     = dec.aluop;
        run_cw[CW_INC_PC] = dec.skz & bus.zero;
        run_cw[CW_LD_PC]  = dec.jmp;
        run_cw[CW_DATA_E] = dec.sto;
      end
      PH_STORE: begin
        run_cw[CW_RD]     = dec.aluop;
        run_cw[CW_LD_AC]  = dec.aluop;
        run_cw[CW_LD_PC]  = dec.jmp;
        run_cw[CW_WR]     = dec.sto;
        run_cw[CW_DATA_E] = dec.sto;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cw       = '0;
    case (state_q)
      ST_RUN: begin
        cw = run_cw;
        if (halt_req) begin
          state_d = ST_HALTED;
        end else begin
          cnt_en = bus.enable & ~stall;
        end
      end
      ST_HALTED: begin
        cw[CW_HALT] = 1'b1;
        // Resuming skips the operand-address phase that issued the halt.
        if (bus.resume) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      trap_q <= 1'b0;
    end else if ((state_q == ST_HALTED) && bus.resume) begin
      trap_q <= 1'b0;
    end else if ((state_q == ST_RUN) && halt_req && trap_req) begin
      trap_q <= 1'b1;
    end
  end

  assign bus.trap = trap_q;
`endif

  assign bus.phase  = phase;
  assign bus.halted = (state_q == ST_HALTED);
  assign bus.sel    = cw[CW_SEL];
  assign bus.rd     = cw[CW_RD];
  assign bus.ld_ir  = cw[CW_LD_IR];
  assign bus.halt   = cw[CW_HALT];
  assign bus.inc_pc = cw[CW_INC_PC];
  assign bus.ld_ac  = cw[CW_LD_AC];
  assign bus.ld_pc  = cw[CW_LD_PC];
  assign bus.wr     = cw[CW_WR];
  assign bus.data_e = cw[CW_DATA_E];

endmodule

// File: tb/tb_seq_controller.sv
// Scenario bench for seq_controller: per-cycle expectations are pushed to a
// scoreboard as stimulus is applied and popped when outputs settle.
module tb_seq_controller;

  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  seq_controller_if #(.OPCODE_WIDTH(OW), .PHASE_WIDTH(3)) bus ();

  seq_controller #(
    .OPCODE_WIDTH(OW),
    .PHASE_WIDTH (3)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  typedef struct {
    string      name;
    int         ph;
    bit         hl;
    logic [8:0] cw;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] dut_cw;

  assign dut_cw = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                   bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};

  // Reference strobe table {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}.
  function automatic logic [8:0] model_cw(int ph, int op, bit z, bit hl);
    bit alu, sto, jmp, skz, hlt;
    alu = (op >= 2) && (op <= 5);
    sto = (op == 6);
    jmp = (op == 7);
    skz = (op == 1);
    hlt = (op == 0);
    if (hl) return 9'b000100000;
    case (ph)
      0:       return 9'b100000000;
      1:       return 9'b110000000;
      2, 3:    return 9'b111000000;
      4:       return {3'b000, hlt, 1'b1, 4'b0000};
      5:       return {1'b0, alu, 7'b0000000};
      6:       return {1'b0, alu, 2'b00, skz & z, 1'b0, jmp, 1'b0, sto};
      default: return {1'b0, alu, 3'b000, alu, jmp, sto, sto};
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_ = 1'b0; bus.enable = 1'b1; bus.mem_ready = 1'b1;
    bus.opcode = 4'd2; bus.zero = 1'b0; bus.resume = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      e.name = "reset"; e.ph = 0; e.hl = 1'b0; e.cw = 9'b100000000;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    rst_ = 1'b1;
  endtask

  task automatic test_alu_op();
    exp_t e;
    bus.opcode = 4'd2; bus.mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.enable = (i != 8);
      e.name = "alu_op"; e.ph = i % 8; e.hl = 1'b0; e.cw = model_cw(i % 8, 2, 1'b0, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_fetch_stall();
    exp_t e;
    int ph [12] = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7};
    bit mr [12] = '{1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
    bit en [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    bus.opcode = 4'd4;
    for (int i = 0; i < 12; i++) begin
      bus.mem_ready = mr[i]; bus.enable = en[i];
      e.name = "fetch_stall"; e.ph = ph[i]; e.hl = 1'b0; e.cw = model_cw(ph[i], 4, 1'b0, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1; bus.enable = 1'b1;
  endtask

  task automatic test_store_stall();
    exp_t e;
    int ph [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    bit mr [10] = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 1};
    bus.opcode = 4'd6; bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = mr[i];
      e.name = "store_stall"; e.ph = ph[i]; e.hl = 1'b0; e.cw = model_cw(ph[i], 6, 1'b0, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_skz();
    exp_t e;
    bus.opcode = 4'd1; bus.enable = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.zero = (i < 8);
      e.name = "skz"; e.ph = i % 8; e.hl = 1'b0; e.cw = model_cw(i % 8, 1, i < 8, 1'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_halt_resume();
    exp_t e;
    int ph [19] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 6, 7};
    bit hl [19] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit en [19] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    bus.opcode = 4'd0; bus.mem_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.enable = en[i];
      bus.resume = (i == 15) || (i == 16);
      e.name = "halt_resume"; e.ph = ph[i]; e.hl = hl[i]; e.cw = model_cw(ph[i], 0, 1'b0, hl[i]);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    bus.resume = 1'b0; bus.enable = 1'b1;
  endtask

  task automatic test_illegal_opcode();
    exp_t e;
`ifdef SEQ_ILLEGAL_TRAP_EN
    int ph [11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};
    bit hl [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int n = 11;
`else
    int ph [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0};
    bit hl [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int n = 8;
`endif
    bus.opcode = 4'd9; bus.enable = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.resume = (i == 7) && (n == 11);
      e.name = "illegal_opcode"; e.ph = ph[i]; e.hl = hl[i]; e.cw = model_cw(ph[i], 9, 1'b0, hl[i]);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      checks++;
      if (bus.trap !== hl[i]) begin
        errors++;
        $display("FAIL trap[%0d]: got %b, want %b", i, bus.trap, hl[i]);
      end
`endif
      @(posedge clk); #1;
    end
    bus.resume = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ph [14] = '{0, 1, 2, 3, 4, 5, 5, 0, 1, 2, 3, 4, 4, 0};
    bit hl [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit rs [14] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1};
    bit mr [14] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int op [14] = '{2, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 2};
    bus.enable = 1'b1; bus.resume = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rst_ = rs[i]; bus.mem_ready = mr[i]; bus.opcode = 4'(op[i]);
      e.name = "reset_mid"; e.ph = ph[i]; e.hl = hl[i]; e.cw = model_cw(ph[i], op[i], 1'b0, hl[i]);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.phase !== 3'(e.ph) || bus.halted !== e.hl || dut_cw !== e.cw) begin
        errors++;
        $display("FAIL %s[%0d]: got phase=%0d halted=%b strobes=%b, want phase=%0d halted=%b strobes=%b",
                 e.name, i, bus.phase, bus.halted, dut_cw, e.ph, e.hl, e.cw);
      end
      @(posedge clk); #1;
    end
    rst_ = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_fetch_stall();
    test_store_stall();
    test_skz();
    test_halt_resume();
    test_illegal_opcode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
